// File: rtl/keypad_scan_debounce.sv
// 4x4 active-low keypad scanner with press/release debounce; one new_key strobe per accepted press.
// Press latency at most 2 + 4*SCAN_CYCLES + DEBOUNCE_CYCLES + 1 cycles; no backpressure, strobe is fire-and-forget.
module keypad_scan_debounce #(
  parameter int SCAN_CYCLES     = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        new_key,
  output logic [15:0] key_pressed_value
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    rows_meta, rs;
  logic [1:0]    col, col_nxt;
  logic [1:0]    row_sel, hit_row;
  logic [SW-1:0] dwell_cnt;
  logic [DW-1:0] db_cnt;
  logic [3:0]    col_dec;

  logic rs_row, any_row, dwell_done, db_done;
  logic dwell_clr, dwell_inc, db_clr, db_inc;
  logic col_adv, row_latch, strobe;

  assign rs_row     = rs[row_sel];
  assign any_row    = ~&rs;
  assign dwell_done = (dwell_cnt == SCAN_LAST);
  assign db_done    = (db_cnt == DB_LAST);

  // Lowest-index pressed row wins within the scanned column.
  always_comb begin
    hit_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) hit_row = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SCAN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:       if (dwell_done && any_row) state_nxt = PRESS_DB;
      PRESS_DB:   if (rs_row) state_nxt = SCAN;
                  else if (db_done) state_nxt = HELD;
      HELD:       if (rs_row) state_nxt = RELEASE_DB;
      RELEASE_DB: if (!rs_row) state_nxt = HELD;
                  else if (db_done) state_nxt = SCAN;
      default:    state_nxt = SCAN;
    endcase
  end

  // Counter and datapath controls; dwell is parked at 0 outside SCAN so an abort restarts the column cleanly.
  always_comb begin
    dwell_clr = 1'b0;
    dwell_inc = 1'b0;
    db_clr    = 1'b0;
    db_inc    = 1'b0;
    col_adv   = 1'b0;
    row_latch = 1'b0;
    strobe    = 1'b0;
    case (state)
      SCAN: begin
        if (dwell_done) begin
          dwell_clr = 1'b1;
          if (any_row) begin
            row_latch = 1'b1;
            db_clr    = 1'b1;
          end else begin
            col_adv = 1'b1;
          end
        end else begin
          dwell_inc = 1'b1;
        end
      end
      PRESS_DB: begin
        dwell_clr = 1'b1;
        if (rs_row) begin
          db_clr = 1'b1;
        end else if (db_done) begin
          strobe = 1'b1;
          db_clr = 1'b1;
        end else begin
          db_inc = 1'b1;
        end
      end
      HELD: begin
        dwell_clr = 1'b1;
        db_clr    = 1'b1;
      end
      RELEASE_DB: begin
        dwell_clr = 1'b1;
        if (!rs_row) begin
          db_clr = 1'b1;
        end else if (db_done) begin
          col_adv = 1'b1;
          db_clr  = 1'b1;
        end else begin
          db_inc = 1'b1;
        end
      end
      default: begin
        dwell_clr = 1'b1;
        db_clr    = 1'b1;
      end
    endcase
  end

  assign col_nxt = col_adv ? col + 2'd1 : col;
  assign col_dec = 4'b0001 << col_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_meta         <= 4'hF;
      rs                <= 4'hF;
      col               <= 2'd0;
      cols              <= 4'b1110;
      row_sel           <= 2'd0;
      dwell_cnt         <= '0;
      db_cnt            <= '0;
      new_key           <= 1'b0;
      key_pressed_value <= 16'h0000;
    end else begin
      rows_meta <= rows;
      rs        <= rows_meta;
      col       <= col_nxt;
      cols      <= ~col_dec;
      if (row_latch) row_sel <= hit_row;
      if (dwell_clr)      dwell_cnt <= '0;
      else if (dwell_inc) dwell_cnt <= dwell_cnt + SW'(1);
      if (db_clr)      db_cnt <= '0;
      else if (db_inc) db_cnt <= db_cnt + DW'(1);
      new_key <= strobe;
      if (strobe) key_pressed_value <= 16'h0001 << {row_sel, col};
    end
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Scans a 4x4 active-low matrix keypad and debounces key presses. Emits exactly one single-cycle `new_key` strobe and a one-hot 16-bit key code per debounced press. It is the stage directly upstream of `store_keypresses`, which consumes `new_key` and `key_pressed_value`. Holding a key or bouncing on release never produces a second strobe.

## Interface
- `SCAN_CYCLES`, default 50000: dwell cycles per column, ≥ 4.
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a press or a release, ≥ 2.

- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rows` in 4: raw keypad row inputs, active-low (0 = pressed), asynchronous to `clk`.
- `cols` out 4: column drives, active-low; exactly one bit is 0 at all times.
- `new_key` out 1: one-cycle strobe for each debounced press.
- `key_pressed_value` out 16: one-hot code, bit index = row*4 + col; holds the last accepted key.

## Operation
- `rows` passes through a 2-flop synchronizer. All logic uses the synchronized value `rs`.
- FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
- SCAN:
  - Drive column `c`.
  - Dwell counter runs 0..SCAN_CYCLES-1.
  - Sample `rs` only when the counter is at SCAN_CYCLES-1.
  - If any `rs` bit is 0, latch row `r` = lowest index with a 0, freeze `c`, and go to PRESS_DB with the debounce counter at 0.
  - Otherwise advance `c` (3 wraps to 0) and clear the dwell counter.
- PRESS_DB:
  - Column `c` stays driven.
  - Each cycle that `rs[r]` is 0, increment the counter.
  - If `rs[r]` is 1, return to SCAN on the same column with the dwell counter at 0. No strobe.
  - When the counter reaches DEBOUNCE_CYCLES-1 with `rs[r]` still 0:
    - next cycle, `new_key` = 1 and `key_pressed_value` = 1 << (r*4+c), both in the same cycle;
    - go to HELD.
- HELD:
  - Column `c` stays driven.
  - Other keys are ignored, including keys in the same column on other rows.
  - When `rs[r]` = 1, go to RELEASE_DB with the counter at 0.
- RELEASE_DB:
  - Count consecutive cycles with `rs[r]` = 1.
  - If `rs[r]` returns to 0, go back to HELD. No strobe.
  - After DEBOUNCE_CYCLES consecutive cycles, go to SCAN, advance `c`, and clear the dwell counter.
- Multiple keys pressed at once: the first column reached in scan order wins; within that column, the lowest row wins.
- `new_key` is never high for two consecutive cycles. It is high at most once per press-to-release cycle.

## Timing
- Reset values:
  - state SCAN, `c` = 0;
  - `cols` = 4'b1110;
  - dwell and debounce counters 0;
  - `new_key` = 0, `key_pressed_value` = 16'h0000;
  - synchronizer flops all 1.
- Reset mid-operation: all of the above apply on the next edge. A strobe in progress is dropped.
- `cols` is registered and changes on the clock edge after the dwell counter wraps.
- Synchronizer latency is 2 cycles. SCAN_CYCLES ≥ 4 guarantees the sample reflects the currently driven column.
- Press latency, measured from a stable pressed level on `rows` (column already driven, PRESS_DB entry sample included): at most 2 + SCAN_CYCLES*4 + DEBOUNCE_CYCLES + 1 cycles to `new_key`.
- `key_pressed_value` changes only in the `new_key` cycle and is stable otherwise.
- Counters are sized as clog2 of their parameter and must never wrap past their terminal count.

## Test plan
Parameters for all scenarios: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.

1. Reset, `rows` = 4'hF for 40 cycles:
   - `cols` cycles 1110→1101→1011→0111→1110, each held 4 cycles;
   - `new_key` stays 0 and `key_pressed_value` = 0.
2. Model a press of row 2, col 1 (`rows[2]` = 0 only while `cols[1]` = 0), held 30 cycles:
   - exactly one `new_key` pulse;
   - `key_pressed_value` = 16'h0200;
   - `cols` frozen at 1101 until release.
3. Bounce: row 0, col 0 low for 5 cycles, high for 1 cycle, then low for 20 cycles:
   - the first attempt aborts with no strobe;
   - one strobe with value 16'h0001 after the stable run.
4. Release bounce: after an accepted press of 16'h0001, toggle `rows[0]` high/low every 3 cycles, then hold high for 10 cycles:
   - no second strobe;
   - scanning resumes at `cols` = 1101.
5. Simultaneous keys (row 1, col 3) and (row 3, col 3):
   - single strobe with 16'h0080 (row 1 wins);
   - releasing row 3 alone, or holding it, causes no strobe;
   - releasing row 1 returns to SCAN.
6. Assert `reset` for 1 cycle during PRESS_DB (counter = 5):
   - `cols` = 1110, no `new_key`, `key_pressed_value` = 0 on the next cycle;
   - the same key held afterward is re-detected and strobed exactly once.
